// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader: sweeps a fixed table of 11 RTC registers over the multiplexed
// AD bus and hands each value to the register bank with a one-cycle AoD low.
module rtc_bus_reader #(
  parameter int unsigned T_PHASE     = 4,
  parameter int unsigned REFRESH_GAP = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       rtc_ad,
  output logic [7:0] address,
  output logic [7:0] data_vga,
  output logic       AoD,
  output logic       busy,
  output logic       sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASETUP,
    S_AWRITE,
    S_AHOLD,
    S_DREAD,
    S_PUBLISH,
    S_RECOVER,
    S_WAIT
  } state_e;

  localparam logic [3:0]  LAST_IDX   = 4'd10;
  localparam logic [7:0]  PHASE_LAST = 8'(T_PHASE - 1);
  localparam int unsigned GAP_CYCLES = (REFRESH_GAP == 0) ? 1 : REFRESH_GAP;
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h27;
      4'd7:    reg_addr = 8'h28;
      4'd8:    reg_addr = 8'h41;
      4'd9:    reg_addr = 8'h42;
      default: reg_addr = 8'h43;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] gap_q, gap_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  address_q, address_d;
  logic [7:0]  data_q, data_d;
  logic        sweep_done_q, sweep_done_d;
  logic        phase_last;

  // NOTE: state registers use non-blocking assignments only; the synchronous
  // reset also clears address/data because they are directly visible outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 8'd0;
      gap_q        <= 16'd0;
      idx_q        <= 4'd0;
      address_q    <= 8'h00;
      data_q       <= 8'h00;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      address_q    <= address_d;
      data_q       <= data_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    phase_d      = 8'd0;
    gap_d        = 16'd0;
    idx_d        = idx_q;
    address_d    = address_q;
    data_d       = data_q;
    sweep_done_d = 1'b0;
    phase_last   = (phase_q == PHASE_LAST);

    case (state_q)
      S_IDLE: begin
        idx_d = 4'd0;
        if (enable) state_d = S_ASETUP;
      end
      S_ASETUP: begin
        if (phase_last) state_d = S_AWRITE;
        else            phase_d = phase_q + 8'd1;
      end
      S_AWRITE: begin
        if (phase_last) state_d = S_AHOLD;
        else            phase_d = phase_q + 8'd1;
      end
      S_AHOLD: begin
        if (phase_last) state_d = S_DREAD;
        else            phase_d = phase_q + 8'd1;
      end
      S_DREAD: begin
        if (phase_last) begin
          data_d  = ad_in;
          state_d = S_PUBLISH;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_PUBLISH: state_d = S_RECOVER;
      S_RECOVER: begin
        if (!phase_last) begin
          phase_d = phase_q + 8'd1;
        end else begin
          // enable is only honoured here and in WAIT so a read always completes
          sweep_done_d = (idx_q == LAST_IDX);
          if (!enable) begin
            idx_d   = 4'd0;
            state_d = S_IDLE;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ASETUP;
          end
        end
      end
      S_WAIT: begin
        if (!enable) begin
          idx_d   = 4'd0;
          state_d = S_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_ASETUP;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ASETUP && state_q != S_ASETUP) address_d = reg_addr(idx_d);
  end

  always_comb begin
    ad_out = 8'h00;
    ad_oe  = 1'b0;
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    rtc_ad = 1'b1;
    case (state_q)
      S_ASETUP, S_AHOLD: begin
        cs_n   = 1'b0;
        rtc_ad = 1'b0;
        ad_oe  = 1'b1;
        ad_out = address_q;
      end
      S_AWRITE: begin
        cs_n   = 1'b0;
        rtc_ad = 1'b0;
        ad_oe  = 1'b1;
        ad_out = address_q;
        wr_n   = 1'b0;
      end
      S_DREAD: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign address    = address_q;
  assign data_vga   = data_q;
  assign AoD        = (state_q != S_PUBLISH);
  assign busy       = (state_q != S_IDLE);
  assign sweep_done = sweep_done_q;

endmodule
